// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter sharing one fixed-latency single-port memory
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int               CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MEM_LAT - 1);
    localparam logic             OWN_FETCH = 1'b0;
    localparam logic             OWN_DATA  = 1'b1;

    generate
        if (MEM_LAT < 1) begin : g_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              owner_q;
    logic              last_owner_q;
    logic              busy_q;
    logic              mem_en_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_gnt_q;
    logic              d_gnt_q;
    logic              if_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              grant_data_d;

    // On a tie the requester that did not own the previous access wins.
    always_comb begin
        grant_data_d = d_req && (!if_req || (last_owner_q == OWN_FETCH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_FETCH;
            last_owner_q <= OWN_FETCH;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            mem_en_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        state_q      <= S_WAIT;
                        busy_q       <= 1'b1;
                        cnt_q        <= CNT_LOAD;
                        mem_en_q     <= 1'b1;
                        mem_wr_q     <= grant_data_d && d_wr;
                        mem_addr_q   <= grant_data_d ? d_addr : if_addr;
                        mem_wdata_q  <= grant_data_d ? d_wdata : '0;
                        d_gnt_q      <= grant_data_d;
                        if_gnt_q     <= !grant_data_d;
                        owner_q      <= grant_data_d ? OWN_DATA : OWN_FETCH;
                        last_owner_q <= grant_data_d ? OWN_DATA : OWN_FETCH;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    // mem_rdata is valid during RESP; it lands in rdata with the
                    // rvalid pulse, and the following IDLE cycle takes the next grant.
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (owner_q == OWN_DATA) begin
                        d_rvalid_q <= 1'b1;
                        if (!mem_wr_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                    end else begin
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= mem_rdata;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (MEM_LAT 2 and 1)
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_wr, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_wr, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_d_req, b_d_wr, b_d_gnt, b_d_rvalid;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic        b_mem_en, b_mem_wr, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit pick_data(input bit f, input bit d, input bit last_was_data);
        if (f && d) return !last_was_data;
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: word for the access appears only in the cycle LAT after mem_en.
    int          en_n = -100, b_en_n = -100;
    logic [31:0] en_addr = '0, b_en_addr = '0;
    always @(negedge clk) begin
        if (!rst) begin
            en_n   <= -100;
            b_en_n <= -100;
        end else begin
            if (mem_en) begin
                en_n    <= cyc;
                en_addr <= mem_addr;
            end
            if (b_mem_en) begin
                b_en_n    <= cyc;
                b_en_addr <= b_mem_addr;
            end
            mem_rdata   <= (cyc == en_n + LAT) ? mem_word(en_addr) : (32'hBAD0_0000 ^ 32'(cyc));
            b_mem_rdata <= (cyc == b_en_n + 1) ? mem_word(b_en_addr) : (32'hBAD1_0000 ^ 32'(cyc));
        end
    end

    // Transaction-level reference for the MEM_LAT=2 instance.
    int          a_gnt = -100, a_rv = -100, next_ok = 0;
    logic        a_data = 1'b0, a_wr = 1'b0, last_data = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_gnt <= -100; a_rv <= -100; next_ok <= 0; last_data <= 1'b0;
            a_data <= 1'b0; a_wr <= 1'b0; a_addr <= '0; a_wdata <= '0;
            e_if_rdata <= '0; e_d_rdata <= '0;
        end else begin
            if (cyc == a_rv - 1) begin
                if (!a_data) e_if_rdata <= mem_word(a_addr);
                else if (!a_wr) e_d_rdata <= mem_word(a_addr);
            end
            if (cyc >= next_ok && (if_req || d_req)) begin
                a_data    <= pick_data(if_req, d_req, last_data);
                last_data <= pick_data(if_req, d_req, last_data);
                a_wr      <= pick_data(if_req, d_req, last_data) && d_wr;
                a_addr    <= pick_data(if_req, d_req, last_data) ? d_addr : if_addr;
                a_wdata   <= d_wdata;
                a_gnt     <= cyc + 1;
                a_rv      <= cyc + LAT + 2;
                next_ok   <= cyc + LAT + 2;
            end
        end
    end

    always @(negedge clk) begin
        check("if_gnt", 32'(if_gnt), 32'(a_gnt == cyc && !a_data));
        check("d_gnt", 32'(d_gnt), 32'(a_gnt == cyc && a_data));
        check("mem_en", 32'(mem_en), 32'(a_gnt == cyc));
        check("busy", 32'(busy), 32'(cyc >= a_gnt && cyc < a_rv));
        check("if_rvalid", 32'(if_rvalid), 32'(a_rv == cyc && !a_data));
        check("d_rvalid", 32'(d_rvalid), 32'(a_rv == cyc && a_data));
        check("if_rdata", if_rdata, e_if_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        if (a_gnt < 0) begin
            check("mem_addr_rst", mem_addr, 32'h0);
            check("mem_wr_rst", 32'(mem_wr), 32'h0);
            check("mem_wdata_rst", mem_wdata, 32'h0);
        end else if (cyc >= a_gnt && cyc < a_rv - 1) begin
            check("mem_addr_hold", mem_addr, a_addr);
            check("mem_wr_hold", 32'(mem_wr), 32'(a_wr));
            if (a_wr) check("mem_wdata_hold", mem_wdata, a_wdata);
        end
    end

    task automatic single(input bit dat, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata);
        if (dat) begin
            d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(negedge clk);
        check(dat ? "dir_d_gnt" : "dir_if_gnt", 32'(dat ? d_gnt : if_gnt), 32'h1);
        check("dir_mem_en", 32'(mem_en), 32'h1);
        check("dir_mem_addr", mem_addr, addr);
        check("dir_mem_wr", 32'(mem_wr), 32'(dat && wr));
        if (dat && wr) check("dir_mem_wdata", mem_wdata, wdata);
        d_req = 1'b0;
        if_req = 1'b0;
        for (int k = 2; k <= LAT + 1; k++) begin
            @(negedge clk);
            check("dir_no_rvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
        end
        @(negedge clk);
        check(dat ? "dir_d_rvalid" : "dir_if_rvalid", 32'(dat ? d_rvalid : if_rvalid), 32'h1);
        check(dat ? "dir_d_rdata" : "dir_if_rdata", dat ? d_rdata : if_rdata, exp_rdata);
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_wr = 0; b_d_addr = '0; b_d_wdata = '0;

        // Reset state and quiet idle period after release.
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_wr, busy}), 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_strobes", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, busy}), 32'h0);
        end

        // MEM_LAT=1 instance: fetch of 0x20.
        b_if_req = 1'b1; b_if_addr = 32'h20;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("lat1_if_gnt", 32'(b_if_gnt), 32'(k == 1));
            check("lat1_if_rvalid", 32'(b_if_rvalid), 32'(k == 3));
            check("lat1_busy", 32'(b_busy), 32'(k == 1 || k == 2));
            check("lat1_d_side", 32'({b_d_gnt, b_d_rvalid, b_mem_wr}), 32'h0);
            if (k == 1) b_if_req = 1'b0;
            if (k == 3) check("lat1_if_rdata", b_if_rdata, mem_word(32'h20));
        end
        check("lat1_d_rdata", b_d_rdata, 32'h0);

        // Fetch, then load, then store that leaves d_rdata alone.
        single(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0093);
        @(negedge clk);
        check("if_rdata_holds", if_rdata, 32'h0050_0093);
        single(1'b1, 1'b0, 32'h40, 32'h0, mem_word(32'h40));
        single(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, mem_word(32'h40));

        // Contention straight after reset: D, F, D.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h44;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("rr_d_gnt", 32'(d_gnt), 32'(k == 1 || k == 9));
            check("rr_if_gnt", 32'(if_gnt), 32'(k == 5));
            check("rr_d_rvalid", 32'(d_rvalid), 32'(k == 4));
            check("rr_if_rvalid", 32'(if_rvalid), 32'(k == 8));
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of a load.
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h80;
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_rst_outputs", 32'({busy, mem_en, mem_wr, d_gnt, d_rvalid}), 32'h0);
        check("async_rst_mem_addr", mem_addr, 32'h0);
        check("async_rst_d_rdata", d_rdata, 32'h0);
        check("async_rst_if_rdata", if_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_rvalid_after_rst", 32'({if_rvalid, d_rvalid}), 32'h0);
        end
        single(1'b0, 1'b0, 32'h30, 32'h0, mem_word(32'h30));

        // Random traffic; requests stay up until granted, one mid-run reset.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst = (i != 300);
            if (if_gnt) if_req = 1'b0;
            if (d_gnt) d_req = 1'b0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'h0000_FFFC;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
                d_addr = $urandom & 32'h0000_FFFC; d_wdata = $urandom;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
